// File: rtl/frame_buf_scheduler.sv
// Frame buffer scheduler: rotates a stream writer across C_BUF_NUM frame
// buffers while letting a reader pin the most recently completed frame.
//
// Ports:
//   M_AXI_ACLK, M_AXI_ARESETN  clock, asynchronous active-low reset
//   enable                     level request to run the writer
//   buf_base, buf_stride       address of buffer 0 and byte distance between buffers
//   soft_reset                 held high to the writer while idle
//   resetting                  writer still busy flushing
//   frame_pulse                writer start-of-frame; base_addr valid next cycle
//   base_addr, wr_idx          buffer the writer fills
//   rd_req, rd_release         reader acquire / release pulses
//   rd_idx, rd_valid           buffer granted to the reader; a completed frame exists
//   frame_cnt, running         completed-frame count; scheduler in RUN
module frame_buf_scheduler #(
  parameter int unsigned C_M_AXI_ADDR_WIDTH = 32,
  parameter int unsigned C_BUF_NUM          = 3,
  parameter int unsigned C_CNT_BITS         = 16
) (
  input  logic                          M_AXI_ACLK,
  input  logic                          M_AXI_ARESETN,
  input  logic                          enable,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0] buf_base,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0] buf_stride,
  output logic                          soft_reset,
  input  logic                          resetting,
  input  logic                          frame_pulse,
  output logic [C_M_AXI_ADDR_WIDTH-1:0] base_addr,
  output logic [1:0]                    wr_idx,
  input  logic                          rd_req,
  input  logic                          rd_release,
  output logic [1:0]                    rd_idx,
  output logic                          rd_valid,
  output logic [C_CNT_BITS-1:0]         frame_cnt,
  output logic                          running
);

  localparam int unsigned AW = C_M_AXI_ADDR_WIDTH;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FLUSH = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [1:0]          latest;
  logic                rd_lock;
  logic                wr_active;

  logic [1:0]          latest_nxt;
  logic                rd_lock_nxt;
  logic                wr_active_nxt;
  logic                rd_valid_nxt;
  logic [1:0]          rd_idx_nxt;
  logic [1:0]          wr_idx_nxt;
  logic [AW-1:0]       base_nxt;
  logic [C_CNT_BITS-1:0] cnt_nxt;
  logic [1:0]          pick;

  // Lowest buffer that is neither the published frame nor the reader's pinned
  // buffer; falls back to the current buffer when none is free.
  function automatic logic [1:0] pick_free(
    input logic       ex_a_en,
    input logic [1:0] ex_a,
    input logic       ex_b_en,
    input logic [1:0] ex_b,
    input logic [1:0] keep
  );
    logic [1:0] sel;
    logic       found;
    sel   = keep;
    found = 1'b0;
    for (int unsigned i = 0; i < C_BUF_NUM; i++) begin
      if (!found && !(ex_a_en && ex_a == 2'(i)) && !(ex_b_en && ex_b == 2'(i))) begin
        sel   = 2'(i);
        found = 1'b1;
      end
    end
    return sel;
  endfunction

  function automatic logic [AW-1:0] addr_of(input logic [1:0] idx);
    return buf_base + AW'(idx) * buf_stride;
  endfunction

  // State register
  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) state <= ST_IDLE;
    else                state <= state_nxt;
  end

  // Next-state and buffer bookkeeping
  always_comb begin
    state_nxt     = state;
    latest_nxt    = latest;
    rd_lock_nxt   = rd_lock;
    wr_active_nxt = wr_active;
    rd_valid_nxt  = rd_valid;
    rd_idx_nxt    = rd_idx;
    wr_idx_nxt    = wr_idx;
    base_nxt      = base_addr;
    cnt_nxt       = frame_cnt;
    pick          = wr_idx;

    // Reader acquire beats release; the grant uses the pre-commit frame.
    if (rd_req && rd_valid) begin
      rd_idx_nxt  = latest;
      rd_lock_nxt = 1'b1;
    end else if (rd_release) begin
      rd_lock_nxt = 1'b0;
    end

    case (state)
      ST_IDLE: begin
        if (enable) state_nxt = ST_FLUSH;
      end
      ST_FLUSH: begin
        if (!enable) begin
          state_nxt = ST_IDLE;
        end else if (!resetting) begin
          state_nxt     = ST_RUN;
          wr_active_nxt = 1'b0;
          pick          = pick_free(rd_valid, latest, rd_lock_nxt, rd_idx_nxt, wr_idx);
          wr_idx_nxt    = pick;
          base_nxt      = addr_of(pick);
        end
      end
      ST_RUN: begin
        if (!enable) begin
          state_nxt     = ST_IDLE;
          rd_valid_nxt  = 1'b0;
          wr_active_nxt = 1'b0;
        end else if (frame_pulse) begin
          // A pulse closes the frame in progress (if any) and opens the next.
          if (wr_active) begin
            latest_nxt   = wr_idx;
            rd_valid_nxt = 1'b1;
            cnt_nxt      = frame_cnt + C_CNT_BITS'(1);
          end
          wr_active_nxt = 1'b1;
          pick          = pick_free(rd_valid_nxt, latest_nxt, rd_lock_nxt, rd_idx_nxt, wr_idx);
          wr_idx_nxt    = pick;
          base_nxt      = addr_of(pick);
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Registered datapath and outputs
  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) begin
      soft_reset <= 1'b1;
      running    <= 1'b0;
      base_addr  <= '0;
      wr_idx     <= '0;
      rd_idx     <= '0;
      rd_valid   <= 1'b0;
      rd_lock    <= 1'b0;
      wr_active  <= 1'b0;
      latest     <= '0;
      frame_cnt  <= '0;
    end else begin
      soft_reset <= (state_nxt == ST_IDLE);
      running    <= (state_nxt == ST_RUN);
      base_addr  <= base_nxt;
      wr_idx     <= wr_idx_nxt;
      rd_idx     <= rd_idx_nxt;
      rd_valid   <= rd_valid_nxt;
      rd_lock    <= rd_lock_nxt;
      wr_active  <= wr_active_nxt;
      latest     <= latest_nxt;
      frame_cnt  <= cnt_nxt;
    end
  end

endmodule

// File: tb/tb_frame_buf_scheduler.sv
// Bench for frame_buf_scheduler: two instances (3 buffers / 16-bit count and
// 2 buffers / 4-bit count) share one stimulus stream; a rule-level model
// predicts every post-edge output and a monitor compares on the falling edge.
module tb_frame_buf_scheduler;

  localparam int unsigned AW = 32;
  localparam int NB [2] = '{3, 2};
  localparam int CB [2] = '{16, 4};

  localparam int M_IDLE  = 0;
  localparam int M_FLUSH = 1;
  localparam int M_RUN   = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          enable, resetting, frame_pulse, rd_req, rd_release;
  logic [AW-1:0] buf_base, buf_stride;

  logic          sr3, run3, rv3, sr2, run2, rv2;
  logic [AW-1:0] ba3, ba2;
  logic [1:0]    wi3, ri3, wi2, ri2;
  logic [15:0]   fc3;
  logic [3:0]    fc2;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          mode;
    int          wr;
    int          latest;
    bit          rdv;
    bit          lock;
    int          rdi;
    bit          act;
    int          cnt;
    logic [31:0] base;
  } mst_t;

  typedef struct {
    mst_t e [2];
  } exp_t;

  mst_t ms [2];
  exp_t q[$];

  frame_buf_scheduler #(.C_M_AXI_ADDR_WIDTH(AW), .C_BUF_NUM(3), .C_CNT_BITS(16)) dut3 (
    .M_AXI_ACLK(clk), .M_AXI_ARESETN(rst_n), .enable(enable),
    .buf_base(buf_base), .buf_stride(buf_stride), .soft_reset(sr3),
    .resetting(resetting), .frame_pulse(frame_pulse), .base_addr(ba3),
    .wr_idx(wi3), .rd_req(rd_req), .rd_release(rd_release), .rd_idx(ri3),
    .rd_valid(rv3), .frame_cnt(fc3), .running(run3)
  );

  frame_buf_scheduler #(.C_M_AXI_ADDR_WIDTH(AW), .C_BUF_NUM(2), .C_CNT_BITS(4)) dut2 (
    .M_AXI_ACLK(clk), .M_AXI_ARESETN(rst_n), .enable(enable),
    .buf_base(buf_base), .buf_stride(buf_stride), .soft_reset(sr2),
    .resetting(resetting), .frame_pulse(frame_pulse), .base_addr(ba2),
    .wr_idx(wi2), .rd_req(rd_req), .rd_release(rd_release), .rd_idx(ri2),
    .rd_valid(rv2), .frame_cnt(fc2), .running(run2)
  );

  always #5 clk = ~clk;

  function automatic mst_t model_reset();
    mst_t s;
    s.mode = M_IDLE; s.wr = 0; s.latest = 0; s.rdv = 0; s.lock = 0;
    s.rdi = 0; s.act = 0; s.cnt = 0; s.base = '0;
    return s;
  endfunction

  // Lowest buffer index not excluded by the published frame or the reader pin.
  function automatic int pick(int n, bit rdv, int latest, bit lock, int rdi, int cur);
    int cand[$];
    int ok[$];
    for (int i = 0; i < n; i++) cand.push_back(i);
    ok = cand.find(x) with (!(rdv && x == latest) && !(lock && x == rdi));
    if (ok.size() == 0) return cur;
    return ok[0];
  endfunction

  function automatic mst_t model_next(mst_t s, int k, bit en, bit res, bit fp, bit rq, bit rl);
    mst_t o;
    bit   load;
    o    = s;
    load = 0;
    if (rq && s.rdv) begin
      o.rdi  = s.latest;
      o.lock = 1;
    end else if (rl) begin
      o.lock = 0;
    end
    if (s.mode == M_IDLE) begin
      if (en) o.mode = M_FLUSH;
    end else if (!en) begin
      o.mode = M_IDLE; o.rdv = 0; o.act = 0;
    end else if (s.mode == M_FLUSH) begin
      if (!res) begin
        o.mode = M_RUN; o.act = 0; load = 1;
        o.wr = pick(NB[k], s.rdv, s.latest, o.lock, o.rdi, s.wr);
      end
    end else if (fp) begin
      if (s.act) begin
        o.latest = s.wr; o.rdv = 1; o.cnt = (s.cnt + 1) % (1 << CB[k]);
      end
      o.act = 1; load = 1;
      o.wr = pick(NB[k], o.rdv, o.latest, o.lock, o.rdi, s.wr);
    end
    if (load) o.base = buf_base + 32'(o.wr) * buf_stride;
    return o;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_dut(string tag, mst_t e, logic sr, logic run, logic [1:0] wi,
                           logic [31:0] ba, logic [1:0] ri, logic rv, logic [15:0] fc);
    chk({tag, ".soft_reset"}, 64'(sr),  64'(e.mode == M_IDLE));
    chk({tag, ".running"},    64'(run), 64'(e.mode == M_RUN));
    chk({tag, ".wr_idx"},     64'(wi),  64'(e.wr));
    chk({tag, ".base_addr"},  64'(ba),  64'(e.base));
    chk({tag, ".rd_idx"},     64'(ri),  64'(e.rdi));
    chk({tag, ".rd_valid"},   64'(rv),  64'(e.rdv));
    chk({tag, ".frame_cnt"},  64'(fc),  64'(e.cnt));
  endtask

  // Monitor: compare each post-edge expectation away from the active edge
  always @(negedge clk) begin
    exp_t x;
    if (q.size() > 0) begin
      x = q.pop_front();
      check_dut("dut3", x.e[0], sr3, run3, wi3, ba3, ri3, rv3, fc3);
      check_dut("dut2", x.e[1], sr2, run2, wi2, ba2, ri2, rv2, 16'(fc2));
    end
  end

  task automatic push_exp();
    exp_t x;
    x.e[0] = ms[0];
    x.e[1] = ms[1];
    q.push_back(x);
  endtask

  // One clock: apply inputs, advance the model across the edge, queue expectation
  task automatic step(bit en, bit res, bit fp, bit rq, bit rl);
    mst_t n0, n1;
    enable = en; resetting = res; frame_pulse = fp; rd_req = rq; rd_release = rl;
    n0 = model_next(ms[0], 0, en, res, fp, rq, rl);
    n1 = model_next(ms[1], 1, en, res, fp, rq, rl);
    @(posedge clk);
    ms[0] = n0;
    ms[1] = n1;
    push_exp();
    #1;
  endtask

  // Reset asserted between edges: outputs must clear without a clock edge
  task automatic async_reset();
    #5;
    rst_n = 1'b0;
    #1;
    ms[0] = model_reset();
    ms[1] = model_reset();
    check_dut("async3", ms[0], sr3, run3, wi3, ba3, ri3, rv3, fc3);
    check_dut("async2", ms[1], sr2, run2, wi2, ba2, ri2, rv2, 16'(fc2));
    @(posedge clk);
    push_exp();
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    bit en_r;
    rst_n = 1'b0;
    enable = 0; resetting = 1; frame_pulse = 0; rd_req = 0; rd_release = 0;
    buf_base = 32'h1000_0000;
    buf_stride = 32'h0010_0000;
    ms[0] = model_reset();
    ms[1] = model_reset();
    repeat (2) begin
      @(posedge clk);
      push_exp();
    end
    #1;
    rst_n = 1'b1;

    // Bring-up: flush held for three cycles, then RUN on buffer 0
    step(0, 1, 0, 0, 0);
    repeat (3) step(1, 1, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);

    // Rotation with no reader
    repeat (3) begin
      step(1, 0, 1, 0, 0);
      step(1, 0, 0, 0, 0);
    end

    // Reader pins the latest frame, writer must avoid it
    step(1, 0, 0, 1, 0);
    repeat (4) begin
      step(1, 0, 1, 0, 0);
      step(1, 0, 0, 0, 0);
    end
    step(1, 0, 0, 0, 1);
    repeat (2) step(1, 0, 1, 0, 0);

    // Collisions: acquire with frame pulse, acquire with release
    step(1, 0, 1, 1, 0);
    step(1, 0, 1, 0, 0);
    step(1, 0, 0, 1, 1);
    repeat (3) step(1, 0, 1, 0, 0);

    // Disable mid-frame, pulse while idle ignored, then re-enable
    step(0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    step(1, 1, 1, 0, 0);
    step(1, 0, 0, 0, 0);
    repeat (3) step(1, 0, 1, 0, 0);

    // Asynchronous reset in RUN
    async_reset();
    step(1, 1, 0, 0, 0);
    step(1, 0, 0, 0, 0);

    // Randomized traffic
    en_r = 1;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 399) == 0) async_reset();
      if (en_r && $urandom_range(0, 99) == 0) en_r = 0;
      else if (!en_r && $urandom_range(0, 7) == 0) begin
        en_r = 1;
        buf_base = $urandom;
        buf_stride = $urandom;
      end
      step(en_r, $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0,
           $urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0);
    end

    step(1, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("scoreboard_drain", 64'(q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
